// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and pointer helper for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_e;

  // Successor of a requester index, wrapping 7 -> 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] ptr);
    return ptr + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the first set request scanning upward from last_ptr+1, mod 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic [IDX_W-1:0] start;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // Rotate so the scan start sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    start = next_ptr(last_ptr_i);
    rot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req_i[IDX_W'(start + IDX_W'(i))];
    end
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    winner_o = start + off;
    any_o    = |req_i;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter, hold-until-release grants, registered outputs.
// Optional forced release after MAX_HOLD grant cycles when HOLD_TIMEOUT_EN is defined.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_en,
  output logic             busy,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_max_hold_range
    $error("rr_arbiter_8: MAX_HOLD must lie in 2..256");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_en_q, grant_en_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] winner;
  logic             any;
  logic             rel_normal, rel_forced, rel_any;

  rr_pick8 u_pick (
    .req_i      (req),
    .last_ptr_i (last_ptr_q),
    .winner_o   (winner),
    .any_o      (any)
  );

`ifdef HOLD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  // Hold counter: zero while idle so it starts at 0 on the first grant cycle.
  always_comb begin
    hold_cnt_d = (state_q == GRANT) ? hold_cnt_q + CntW'(1) : '0;
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end

  assign rel_forced = (hold_cnt_q == CntW'(MAX_HOLD - 1));
`else
  assign rel_forced = 1'b0;
`endif

  assign rel_normal = done | ~req[grant_idx_q];
  assign rel_any    = rel_normal | rel_forced;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_ptr_q  <= IDX_W'(N_REQ - 1);
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = GRANT;
      GRANT:   if (rel_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the round-robin pointer.
  always_comb begin
    grant_idx_d = grant_idx_q;
    grant_en_d  = grant_en_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    last_ptr_d  = last_ptr_q;
    case (state_q)
      IDLE: begin
        grant_en_d = 1'b0;
        busy_d     = 1'b0;
        if (any) begin
          grant_idx_d = winner;
          grant_en_d  = 1'b1;
          busy_d      = 1'b1;
        end
      end
      GRANT: begin
        if (rel_any) begin
          grant_en_d = 1'b0;
          busy_d     = 1'b0;
          last_ptr_d = grant_idx_q;
          // A normal release on the same edge suppresses the timeout pulse.
          timeout_d  = rel_forced & ~rel_normal;
        end
      end
      default: begin
        grant_en_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign grant_idx = grant_idx_q;
  assign grant_en  = grant_en_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed vector table, timeout sequence,
// then randomized traffic against a behavioural round-robin model.
module tb_rr_arbiter_8;

  localparam int unsigned MAX_HOLD = 4;
`ifdef HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_8 #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .busy      (busy),
    .timeout   (timeout)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       rst;
    bit [7:0] req;
    bit       done;
    bit       en;
    int       idx;
    bit       to;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: who holds the grant, and who was served last.
  bit m_en, m_to;
  int m_idx, m_last, m_cnt;

  task automatic add(input bit r, input bit [7:0] q, input bit d,
                     input bit en, input int idx, input bit to);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.en = en; v.idx = idx; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input bit en, input int idx, input bit to);
    chk({tag, ".grant_en"}, int'(grant_en), int'(en));
    chk({tag, ".busy"}, int'(busy), int'(en));
    chk({tag, ".grant_idx"}, int'(grant_idx), idx);
    chk({tag, ".timeout"}, int'(timeout), int'(to));
  endtask

  // Apply inputs for one rising edge, return 1 time unit after it.
  task automatic edge_in(input bit r, input bit [7:0] q, input bit d);
    rst = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit r, input bit [7:0] q, input bit d);
    bit normal, forced;
    if (r) begin
      m_en = 0; m_to = 0; m_idx = 0; m_last = 7; m_cnt = 0;
    end else if (!m_en) begin
      m_to = 0;
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (m_last + k) % 8;
        if (q[j] && !m_en) begin
          m_en = 1; m_idx = j; m_cnt = 0;
        end
      end
    end else begin
      normal = d || !q[m_idx];
      forced = TO_EN && (m_cnt == MAX_HOLD - 1);
      if (normal || forced) begin
        m_en = 0; m_last = m_idx; m_to = forced && !normal;
      end else begin
        m_cnt++; m_to = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 8'hFF; done = 1'b0;

    // Reset with full requests pending.
    add(1, 8'hFF, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0);
    // Full contention: grant, hold one cycle, done, then one idle gap before the next.
    for (int k = 0; k <= 8; k++) begin
      add(0, 8'hFF, 0, 1, k % 8, 0);
      add(0, 8'hFF, 0, 1, k % 8, 0);
      add(0, 8'hFF, 1, 0, k % 8, 0);
    end
    // Sparse wrap: last grant 6, then req 0000_0101 gives 0 then 2.
    add(0, 8'h40, 0, 1, 6, 0);
    add(0, 8'h40, 1, 0, 6, 0);
    add(0, 8'h05, 0, 1, 0, 0);
    add(0, 8'h05, 1, 0, 0, 0);
    add(0, 8'h05, 0, 1, 2, 0);
    add(0, 8'h05, 1, 0, 2, 0);
    // Release by dropping req[3]; then done coincident with new req[4].
    add(0, 8'h08, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 3, 0);
    add(0, 8'h08, 0, 1, 3, 0);
    add(0, 8'h18, 1, 0, 3, 0);
    add(0, 8'h10, 0, 1, 4, 0);
    add(0, 8'h10, 1, 0, 4, 0);
    // done while idle is ignored.
    add(0, 8'h00, 1, 0, 4, 0);
    // Reset mid-grant at idx 5; regrant via pointer reset to 7.
    add(0, 8'h20, 0, 1, 5, 0);
    add(1, 8'h20, 0, 0, 0, 0);
    add(0, 8'h20, 0, 1, 5, 0);
    add(0, 8'h20, 1, 0, 5, 0);
    // Sole requester is re-granted.
    add(0, 8'h20, 0, 1, 5, 0);
    add(0, 8'h20, 1, 0, 5, 0);
    // Grantee not re-granted when another client waits: 5 served last, 5 and 1 pending -> 1.
    add(0, 8'h22, 0, 1, 1, 0);
    add(0, 8'h22, 1, 0, 1, 0);
    add(0, 8'h22, 0, 1, 5, 0);
    add(0, 8'h22, 1, 0, 5, 0);

    foreach (vecs[i]) begin
      edge_in(vecs[i].rst, vecs[i].req, vecs[i].done);
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].idx, vecs[i].to);
    end

    // Hold with a single requester and no done.
    edge_in(1, 8'h01, 0);
    edge_in(0, 8'h01, 0);
    chk_out("hold.grant", 1, 0, 0);
`ifdef HOLD_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      edge_in(0, 8'h01, 0);
      chk_out($sformatf("hold.cyc%0d", c), 1, 0, 0);
    end
    edge_in(0, 8'h01, 0);
    chk_out("hold.timeout", 0, 0, 1);
    edge_in(0, 8'h01, 0);
    chk_out("hold.regrant", 1, 0, 0);
    // done on the timeout edge wins: no pulse.
    for (int c = 0; c < 3; c++) edge_in(0, 8'h01, 0);
    edge_in(0, 8'h01, 1);
    chk_out("hold.done_wins", 0, 0, 0);
`else
    for (int c = 0; c < 110; c++) begin
      edge_in(0, 8'h01, 0);
      chk(("hold.grant_en"), int'(grant_en), 1);
      chk(("hold.timeout"), int'(timeout), 0);
    end
`endif

    // Randomized traffic against the model.
    edge_in(1, 8'h00, 0);
    model_edge(1, 8'h00, 0);
    begin
      bit [7:0] q;
      q = 8'h00;
      for (int n = 0; n < 3000; n++) begin
        bit r, d;
        r = ($urandom_range(0, 199) == 0);
        d = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) < 3) begin
          q = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
        end
        edge_in(r, q, d);
        model_edge(r, q, d);
        chk_out($sformatf("rnd%0d", n), m_en, m_idx, m_to);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
